// File: rtl/ahb_burst_master.sv
// ahb_burst_master
//   Command-driven AHB-Lite master. One accepted command becomes one complete
//   burst (SINGLE, INCR with length, INCR4/8/16, WRAP4/8/16) with pipelined
//   address/data phases, HREADY stall handling and two-cycle ERROR handling.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   cmd_*_i / cmd_ready_o
//                     command interface. A command is taken on a cycle where
//                     cmd_valid_i && cmd_ready_o; cmd_ready_o is high only in
//                     IDLE, and cmd_valid_i must hold its fields stable until
//                     that cycle.
//   wdata_i / wdata_req_o
//                     write data source; wdata_req_o marks the cycle wdata_i
//                     is captured into HWDATA.
//   rdata_o / rdata_valid_o
//                     read data, one pulse per completed read beat.
//   done_o / err_o    end-of-command pulse; err_o qualifies it.
//   h*_o / h*_i       AHB-Lite master signals.
module ahb_burst_master #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int HBURST_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [HBURST_WIDTH-1:0] cmd_burst_i,
  input  logic [2:0]              cmd_size_i,
  input  logic                    cmd_write_i,
  input  logic [4:0]              cmd_len_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    wdata_req_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rdata_valid_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   haddr_o,
  output logic [1:0]              htrans_o,
  output logic [HBURST_WIDTH-1:0] hburst_o,
  output logic [2:0]              hsize_o,
  output logic                    hwrite_o,
  output logic [DATA_WIDTH-1:0]   hwdata_o,
  input  logic                    hready_i,
  input  logic [DATA_WIDTH-1:0]   hrdata_i,
  input  logic                    hresp_i
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] MAX_SIZE  = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR, S_DONE
  } state_t;

  state_t                  state_q;
  logic                    cmd_ready_q;
  logic [ADDR_WIDTH-1:0]   haddr_q;
  logic [1:0]              htrans_q;
  logic [HBURST_WIDTH-1:0] hburst_q;
  logic [2:0]              hsize_q;
  logic                    hwrite_q;
  logic [DATA_WIDTH-1:0]   hwdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rdata_valid_q;
  logic                    done_q;
  logic                    err_q;
  logic [4:0]              beats_q;     // address phases still to be accepted
  logic                    wrap_q;
  logic                    undef_q;     // undefined-length INCR: 1KB rule applies
  logic [ADDR_WIDTH-1:0]   mask_q;      // wrap boundary minus one
  logic                    dphase_q;    // a data phase is in progress
  logic                    dwrite_q;    // direction of that data phase

  // Command decode
  logic [4:0]            cmd_beats;
  logic                  cmd_wrap;
  logic                  cmd_illegal;
  logic [ADDR_WIDTH-1:0] cmd_mask;
  logic [ADDR_WIDTH-1:0] cmd_align;

  always_comb begin
    cmd_beats = 5'd1;
    case (cmd_burst_i[2:0])
      3'b000:  cmd_beats = 5'd1;
      3'b001:  cmd_beats = (cmd_len_i == 5'd0) ? 5'd1 :
                           (cmd_len_i > 5'd16) ? 5'd16 : cmd_len_i;
      default: cmd_beats = 5'd2 << cmd_burst_i[2:1];   // 01->4, 10->8, 11->16
    endcase
    cmd_wrap    = !cmd_burst_i[0] && (cmd_burst_i[2:1] != 2'b00);
    cmd_illegal = cmd_size_i > MAX_SIZE;
    cmd_mask    = (ADDR_WIDTH'(cmd_beats) << cmd_size_i) - ONE;
    cmd_align   = cmd_addr_i & ~((ONE << cmd_size_i) - ONE);
  end

  // Next beat address and the 1KB crossing test
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  cross_1k;

  always_comb begin
    incr_addr = haddr_q + (ONE << hsize_q);
    next_addr = wrap_q ? ((haddr_q & ~mask_q) | (incr_addr & mask_q)) : incr_addr;
    cross_1k  = undef_q && (next_addr[9:0] == 10'd0);
  end

  // An address phase is taken on HREADY unless the ongoing data phase is
  // erroring (in which case the pending address is dropped).
  logic addr_acc;
  logic data_ok;
  assign addr_acc    = htrans_q[1] && hready_i && !(dphase_q && hresp_i);
  assign data_ok     = dphase_q && hready_i && !hresp_i;
  assign wdata_req_o = addr_acc && hwrite_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      haddr_q       <= '0;
      htrans_q      <= HT_IDLE;
      hburst_q      <= '0;
      hsize_q       <= '0;
      hwrite_q      <= 1'b0;
      hwdata_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      beats_q       <= '0;
      wrap_q        <= 1'b0;
      undef_q       <= 1'b0;
      mask_q        <= '0;
      dphase_q      <= 1'b0;
      dwrite_q      <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;

      if (data_ok && !dwrite_q) begin
        rdata_q       <= hrdata_i;
        rdata_valid_q <= 1'b1;
      end
      if (dphase_q && hready_i) dphase_q <= 1'b0;
      if (addr_acc) begin
        dphase_q <= 1'b1;
        dwrite_q <= hwrite_q;
        if (hwrite_q) hwdata_q <= wdata_i;
      end

      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (cmd_illegal) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q  <= S_ADDR;
              haddr_q  <= cmd_align;
              htrans_q <= HT_NONSEQ;
              hburst_q <= cmd_burst_i;
              hsize_q  <= cmd_size_i;
              hwrite_q <= cmd_write_i;
              beats_q  <= cmd_beats;
              wrap_q   <= cmd_wrap;
              undef_q  <= (cmd_burst_i[2:0] == 3'b001);
              mask_q   <= cmd_mask;
            end
          end
        end
        S_ADDR, S_BURST: begin
          if (dphase_q && hresp_i) begin
            htrans_q <= HT_IDLE;
            if (hready_i) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_ERR;
            end
          end else if (addr_acc) begin
            beats_q <= beats_q - 5'd1;
            if (beats_q == 5'd1) begin
              htrans_q <= HT_IDLE;
              state_q  <= S_LAST;
            end else begin
              haddr_q  <= next_addr;
              htrans_q <= cross_1k ? HT_NONSEQ : HT_SEQ;
              state_q  <= S_BURST;
            end
          end
        end
        S_LAST: begin
          if (hresp_i) begin
            if (hready_i) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_ERR;
            end
          end else if (hready_i) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_ERR: begin
          if (hready_i) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign haddr_o       = haddr_q;
  assign htrans_o      = htrans_q;
  assign hburst_o      = hburst_q;
  assign hsize_o       = hsize_q;
  assign hwrite_o      = hwrite_q;
  assign hwdata_o      = hwdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: doc/ahb_burst_master.md
Name: ahb_burst_master

Overview:
- Command-driven AHB-Lite master that generates complete, protocol-correct bursts: SINGLE, INCR, and INCR/WRAP 4/8/16.
- Sits directly upstream of the ahb2apb bridge and drives its AHB slave port.
- Replaces ad-hoc burst sequencing with a synthesizable engine that handles wrap addressing, HREADY stalls and ERROR responses.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- HBURST_WIDTH, 3, HBURST width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o.
- cmd_addr_i  in  ADDR_WIDTH  start address.
- cmd_burst_i  in  HBURST_WIDTH  burst type, AHB HBURST encoding.
- cmd_size_i  in  3  transfer size, AHB HSIZE encoding.
- cmd_write_i  in  1  1 = write.
- cmd_len_i  in  5  beat count for INCR only; 0 and 1 both mean 1, maximum 16.
- wdata_i  in  DATA_WIDTH  write data for the next beat; always valid.
- wdata_req_o  out  1  pulse: wdata_i consumed this cycle.
- rdata_o  out  DATA_WIDTH  read data.
- rdata_valid_o  out  1  pulse: rdata_o valid.
- done_o  out  1  pulse: command finished.
- err_o  out  1  qualifies done_o; 1 = burst terminated by error or illegal command.
- haddr_o  out  ADDR_WIDTH  HADDR.
- htrans_o  out  2  HTRANS.
- hburst_o  out  HBURST_WIDTH  HBURST.
- hsize_o  out  3  HSIZE.
- hwrite_o  out  1  HWRITE.
- hwdata_o  out  DATA_WIDTH  HWDATA.
- hready_i  in  1  HREADY.
- hrdata_i  in  DATA_WIDTH  HRDATA.
- hresp_i  in  1  HRESP.

Behaviour:
- Reset values: all outputs 0, htrans_o = IDLE, cmd_ready_o = 0; FSM in IDLE.
- Reset is asynchronous; assertion mid-burst aborts immediately. done_o is not pulsed for the aborted burst.
- FSM states:
  - IDLE: cmd_ready_o = 1. On accept, go to ADDR, or go to DONE with err if the command is illegal.
  - ADDR: first beat, htrans_o = NONSEQ.
  - BURST: overlapped address and data phases, htrans_o = SEQ.
  - LAST: final data phase, htrans_o = IDLE.
  - ERR: second cycle of the error response.
  - DONE: one-cycle done_o pulse, then IDLE.
- Illegal command: cmd_size_i > log2(DATA_WIDTH/8). Result is a done_o + err_o pulse one cycle after accept, with no bus activity.
- Beat count:
  - SINGLE = 1.
  - INCR = max(cmd_len_i, 1).
  - x4 = 4, x8 = 8, x16 = 16.
- Address alignment: the start address has its low cmd_size_i bits forced to 0.
- Bytes per beat: B = 1 << size.
- Next address:
  - INCR types: addr + B.
  - WRAP types: boundary W = beats*B; next = (addr & ~(W-1)) | ((addr + B) & (W-1)).
- 1KB rule for INCR (undefined length) only: if the next address crosses a 1KB boundary, that beat is issued as NONSEQ with hburst_o = INCR. Fixed-length INCR bursts are never split; software must not request them across 1KB.
- Pipelining:
  - Address phase of beat n+1 coincides with data phase of beat n.
  - While hready_i = 0, haddr_o, htrans_o, hburst_o, hsize_o, hwrite_o and hwdata_o are all held stable.
- Address-phase acceptance: hready_i = 1 with htrans_o in NONSEQ/SEQ.
  - For writes, the same edge loads hwdata_o <= wdata_i for that beat's data phase, and wdata_req_o pulses that cycle.
- Data-phase completion: hready_i = 1 with hresp_i = 0.
  - For reads, rdata_o <= hrdata_i and rdata_valid_o pulses the next cycle.
- After the last address is accepted, htrans_o = IDLE (LAST). Completion of the final data phase leads to DONE, where done_o pulses with err_o = 0.
- Error handling:
  - hresp_i = 1 with hready_i = 0 (first error cycle): htrans_o is driven IDLE in the following cycle, and the remaining beats are cancelled.
  - hresp_i = 1 with hready_i = 1 (second cycle): go to DONE with err_o = 1.
  - rdata_valid_o does not pulse for the errored beat.
- cmd_ready_o is 0 in every state except IDLE. Back-to-back commands therefore have at least one IDLE cycle between them.
- Beat counter is 5 bits and counts down. Address arithmetic is modulo 2^ADDR_WIDTH.

Test Plan:
- WRAP8, size 2, write, addr 0x24, hready_i = 1 -> haddr 0x24,28,2C,30,34,38,3C,20; htrans NONSEQ then 7×SEQ then IDLE; 8 wdata_req_o pulses; done_o with err_o = 0.
- INCR4 read at 0x100, hready_i low 2 cycles on beat 2 -> address/control held during the stall; 4 rdata_valid_o pulses carrying the slave data in order.
- INCR, cmd_len_i = 3, size 2, addr 0x3FC -> 0x3FC NONSEQ, 0x400 NONSEQ, 0x404 SEQ.
- WRAP4, size 1, addr 0x06 -> haddr 0x06,08,0A,0C? No: W = 8, so 0x06,00,02,04.
- Read burst with hresp ERROR on beat 3 (two-cycle response) -> htrans IDLE after the first error cycle; done_o + err_o; exactly 2 rdata_valid_o pulses.
- cmd_size_i = 3 with DATA_WIDTH = 32 -> done_o + err_o, htrans stays IDLE.
- Reset asserted mid-WRAP16 -> outputs return to reset values immediately; a new command after release runs cleanly.
